mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset; ports are listed below.
REQ-002 clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 EXE_ResultA  in  32  operand rs (forwarded).
REQ-005 EXE_ResultB  in  32  operand rt (forwarded).
REQ-006 EXE_ALUOp  in  5  operation; recognised: `EXE_ALUOp_MUL, MULT, MULTU (plus MADD, MADDU, MSUB, MSUBU under REQ-026).
REQ-007 EXE_Valid  in  1  instruction in EXE is valid.
REQ-008 EXE_Flush  in  1  exception/branch flush of EXE.
REQ-009 EXE_Stall  in  1  downstream holds EXE this cycle.
REQ-010 HI_In / LO_In  in  32 each  current architectural HI/LO (bypassed).
REQ-011 MUL_Out  out  32  low word of product, feeds ALU MUL_Out.
REQ-012 MUL_HI / MUL_LO  out  32 each  HI/LO write values.
REQ-013 MUL_Busy  out  1  stall request to pipeline control.
REQ-014 MUL_Done  out  1  result valid, HI/LO write enable qualifier.

Function
REQ-015 FSM states SHALL be IDLE, PP, SUM, DONE.
REQ-016 Start SHALL occur when state==IDLE, EXE_Valid=1, EXE_Flush=0 and EXE_ALUOp is a recognised op; operands latched, each extended to 33 bits (sign-extend for MUL/MULT/MADD/MSUB, zero-extend for MULTU/MADDU/MSUBU); next state PP.
REQ-017 PP: four 17x17-bit partial products (hi/lo halves) SHALL be registered; next state SUM.
REQ-018 SUM: partial products SHALL be shifted and summed into a 64-bit product register; next state DONE.
REQ-019 DONE: MUL_Done=1, MUL_Out=product[31:0], {MUL_HI,MUL_LO}=product[63:0]; remain in DONE while EXE_Stall=1, go IDLE when EXE_Stall=0.
REQ-020 MUL_Busy SHALL be combinationally 1 in the start cycle and in PP and SUM, 0 in DONE and idle; fixed latency: start at cycle T, MUL_Done at T+3.
REQ-021 A valid mul op held in EXE during DONE SHALL NOT restart the FSM; restart only from IDLE.
REQ-022 EXE_Flush=1 in any state SHALL force IDLE on the next edge, suppress start, and force MUL_Busy=0 and MUL_Done=0 in that cycle.
REQ-023 Non-recognised ops SHALL leave FSM in IDLE with MUL_Busy=0.
REQ-024 Outputs MUL_Out/HI/LO SHALL hold their last value outside DONE; consumers qualify with MUL_Done.

Reset
REQ-025 resetn=0 SHALL immediately force IDLE, clear operand, partial-product and product registers, MUL_Out=0, MUL_HI=0, MUL_LO=0, MUL_Busy=0, MUL_Done=0, including mid-operation.

Configuration
REQ-026 Macro MUL_MADD_EN: when defined, MADD/MADDU/MSUB/MSUBU SHALL be recognised and SUM SHALL compute {HI_In,LO_In} + product (MADD*) or {HI_In,LO_In} - product (MSUB*) modulo 2^64, sampling HI_In/LO_In at start; when undefined these ops are not recognised (REQ-023) and HI_In/LO_In are unused.

Verification
REQ-027 MULT A=0xFFFFFFFF, B=0x00000002 -> Busy high 3 cycles, Done at T+3, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-028 MULTU A=0xFFFFFFFF, B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE; MUL A=0x00001234, B=0x00010000 -> MUL_Out=0x12340000.
REQ-029 MULT done with EXE_Stall=1 for 4 cycles -> Done stays 1, results stable, no restart; Stall=0 -> IDLE next cycle.
REQ-030 Flush asserted in PP -> Busy=0 and Done=0 that cycle, IDLE next, no Done pulse follows.
REQ-031 resetn low during SUM -> all outputs 0 immediately; after release a new MULT completes with correct 3-cycle latency.
REQ-032 MUL_MADD_EN defined: MADD HI_In=0, LO_In=0xFFFFFFFF, A=1, B=1 -> HI=0x00000001, LO=0x00000000; undefined: same op -> Busy=0, Done never asserts.

Source files
------------

// File: rtl/mul_unit_if.sv
// mul_unit_if: EXE-stage operand/control bundle and HI/LO result bundle
// exchanged between the pipeline and the multiplier.
interface mul_unit_if;
   logic [31:0] EXE_ResultA;
   logic [31:0] EXE_ResultB;
   logic [4:0]  EXE_ALUOp;
   logic        EXE_Valid;
   logic        EXE_Flush;
   logic        EXE_Stall;
   logic [31:0] HI_In;
   logic [31:0] LO_In;
   logic [31:0] MUL_Out;
   logic [31:0] MUL_HI;
   logic [31:0] MUL_LO;
   logic        MUL_Busy;
   logic        MUL_Done;

   // Pipeline side: drives operands/control, consumes results
   modport master (
      output EXE_ResultA, EXE_ResultB, EXE_ALUOp, EXE_Valid, EXE_Flush, EXE_Stall,
      output HI_In, LO_In,
      input  MUL_Out, MUL_HI, MUL_LO, MUL_Busy, MUL_Done
   );

   // Multiplier side
   modport slave (
      input  EXE_ResultA, EXE_ResultB, EXE_ALUOp, EXE_Valid, EXE_Flush, EXE_Stall,
      input  HI_In, LO_In,
      output MUL_Out, MUL_HI, MUL_LO, MUL_Busy, MUL_Done
   );
endinterface

// File: rtl/mul_unit.sv
// mul_unit: fixed 3-cycle 32x32 multiplier (MUL/MULT/MULTU) built from four
// registered 17x17 partial products. Define MUL_MADD_EN to also accept
// MADD/MADDU/MSUB/MSUBU, accumulating into the HI/LO value sampled at start.
module mul_unit (
   input logic       clk,
   input logic       resetn,
   mul_unit_if.slave mif
);
   localparam int unsigned DW  = 32;
   localparam int unsigned XW  = DW + 1;
   localparam int unsigned HW  = 17;
   localparam int unsigned PPW = 2 * HW;
   localparam int unsigned RW  = 2 * DW;

   localparam logic [4:0] OP_MUL   = 5'h10;
   localparam logic [4:0] OP_MULT  = 5'h11;
   localparam logic [4:0] OP_MULTU = 5'h12;
   localparam logic [4:0] OP_MADD  = 5'h13;
   localparam logic [4:0] OP_MADDU = 5'h14;
   localparam logic [4:0] OP_MSUB  = 5'h15;
   localparam logic [4:0] OP_MSUBU = 5'h16;

   typedef enum logic [1:0] {IDLE, PP, SUM, DONE} state_t;

   state_t                 state;
   logic [XW-1:0]          op_a, op_b;
   logic signed [PPW-1:0]  pp_ll, pp_lh, pp_hl, pp_hh;
   logic [RW-1:0]          product;

   logic                   recognised_c, signed_c, accum_c, sub_c, start_c;
   logic [RW-1:0]          prod_sum_c;

   // Opcode decode: which ops start the unit and how operands extend
   always_comb begin
      recognised_c = 1'b0;
      signed_c     = 1'b0;
      accum_c      = 1'b0;
      sub_c        = 1'b0;
      unique case (mif.EXE_ALUOp)
         OP_MUL, OP_MULT: begin recognised_c = 1'b1; signed_c = 1'b1; end
         OP_MULTU:        recognised_c = 1'b1;
`ifdef MUL_MADD_EN
         OP_MADD:  begin recognised_c = 1'b1; signed_c = 1'b1; accum_c = 1'b1; end
         OP_MADDU: begin recognised_c = 1'b1; accum_c = 1'b1; end
         OP_MSUB:  begin recognised_c = 1'b1; signed_c = 1'b1; accum_c = 1'b1; sub_c = 1'b1; end
         OP_MSUBU: begin recognised_c = 1'b1; accum_c = 1'b1; sub_c = 1'b1; end
`endif
         default: ;
      endcase
   end

   assign start_c = resetn && (state == IDLE) && mif.EXE_Valid && !mif.EXE_Flush && recognised_c;

   assign mif.MUL_Busy = !mif.EXE_Flush && (start_c || state == PP || state == SUM);
   assign mif.MUL_Done = !mif.EXE_Flush && (state == DONE);
   assign mif.MUL_Out  = product[DW-1:0];
   assign mif.MUL_HI   = product[RW-1:DW];
   assign mif.MUL_LO   = product[DW-1:0];

   // Recombine partial products: hh<<32 + (lh+hl)<<16 + ll, modulo 2^64
   assign prod_sum_c = ({{(RW-PPW){pp_hh[PPW-1]}}, pp_hh} << DW)
                     + ({{(RW-PPW){pp_lh[PPW-1]}}, pp_lh} << (HW-1))
                     + ({{(RW-PPW){pp_hl[PPW-1]}}, pp_hl} << (HW-1))
                     +  {{(RW-PPW){pp_ll[PPW-1]}}, pp_ll};

`ifdef MUL_MADD_EN
   logic [RW-1:0] acc_base;
   logic          acc_sub;
`else
   logic unused_madd;
   assign unused_madd = ^{mif.HI_In, mif.LO_In, accum_c, sub_c};
`endif

   // Sequencer and datapath registers: IDLE -> PP -> SUM -> DONE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         pp_ll    <= '0;
         pp_lh    <= '0;
         pp_hl    <= '0;
         pp_hh    <= '0;
         product  <= '0;
`ifdef MUL_MADD_EN
         acc_base <= '0;
         acc_sub  <= 1'b0;
`endif
      end else if (mif.EXE_Flush) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: if (start_c) begin
               op_a  <= {signed_c & mif.EXE_ResultA[DW-1], mif.EXE_ResultA};
               op_b  <= {signed_c & mif.EXE_ResultB[DW-1], mif.EXE_ResultB};
`ifdef MUL_MADD_EN
               acc_base <= accum_c ? {mif.HI_In, mif.LO_In} : '0;
               acc_sub  <= sub_c;
`endif
               state <= PP;
            end
            PP: begin
               pp_ll <= $signed({1'b0, op_a[HW-2:0]}) * $signed({1'b0, op_b[HW-2:0]});
               pp_lh <= $signed({1'b0, op_a[HW-2:0]}) * $signed(op_b[XW-1:HW-1]);
               pp_hl <= $signed(op_a[XW-1:HW-1]) * $signed({1'b0, op_b[HW-2:0]});
               pp_hh <= $signed(op_a[XW-1:HW-1]) * $signed(op_b[XW-1:HW-1]);
               state <= SUM;
            end
            SUM: begin
`ifdef MUL_MADD_EN
               product <= acc_sub ? (acc_base - prod_sum_c) : (acc_base + prod_sum_c);
`else
               product <= prod_sum_c;
`endif
               state <= DONE;
            end
            DONE: if (!mif.EXE_Stall) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed + randomised checks of mul_unit with a result scoreboard.
module tb_mul_unit;
   localparam logic [4:0] OP_MUL   = 5'h10;
   localparam logic [4:0] OP_MULT  = 5'h11;
   localparam logic [4:0] OP_MULTU = 5'h12;
   localparam logic [4:0] OP_MADD  = 5'h13;
   localparam logic [4:0] OP_MADDU = 5'h14;
   localparam logic [4:0] OP_MSUB  = 5'h15;
   localparam logic [4:0] OP_MSUBU = 5'h16;

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;
   logic [63:0] sb[$];
   logic [63:0] last_res;

   mul_unit_if mif();
   mul_unit dut (.clk(clk), .resetn(resetn), .mif(mif));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, b, hi, lo);
      logic signed [63:0] sa, sbv;
      logic [63:0] p;
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      case (op)
         OP_MUL, OP_MULT, OP_MADD, OP_MSUB: p = sa * sbv;
         default:                           p = {32'b0, a} * {32'b0, b};
      endcase
      case (op)
         OP_MADD, OP_MADDU: return {hi, lo} + p;
         OP_MSUB, OP_MSUBU: return {hi, lo} - p;
         default:           return p;
      endcase
   endfunction

   // Issue one op from IDLE, require Done exactly 3 cycles after start, compare results
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, b,
                         input logic [63:0] exp);
      int lat;
      logic [63:0] e;
      mif.EXE_ALUOp = op; mif.EXE_ResultA = a; mif.EXE_ResultB = b; mif.EXE_Valid = 1'b1;
      #1;
      chk({tag, "_busy_start"}, 64'(mif.MUL_Busy), 64'd1);
      sb.push_back(exp);
      lat = 0;
      do begin
         tick();
         mif.EXE_Valid = 1'b0;
         #1;
         lat++;
         if (!mif.MUL_Done && lat < 8) chk({tag, "_busy_run"}, 64'(mif.MUL_Busy), 64'd1);
      end while (!mif.MUL_Done && lat < 8);
      chk({tag, "_latency"}, 64'(lat), 64'd3);
      chk({tag, "_busy_done"}, 64'(mif.MUL_Busy), 64'd0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_hilo"}, {mif.MUL_HI, mif.MUL_LO}, e);
         chk({tag, "_out"}, 64'(mif.MUL_Out), 64'(e[31:0]));
         last_res = e;
      end
      tick();
      #1;
      chk({tag, "_done_clear"}, 64'(mif.MUL_Done), 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [4:0]  rop;
      logic [63:0] e;
      last_res = '0;
      resetn = 1'b0;
      mif.EXE_ResultA = 32'hFFFF_FFFF; mif.EXE_ResultB = 32'h2;
      mif.EXE_ALUOp = OP_MULT; mif.EXE_Valid = 1'b1;
      mif.EXE_Flush = 1'b0; mif.EXE_Stall = 1'b0;
      mif.HI_In = 32'h0; mif.LO_In = 32'h0;
      #2;
      chk("reset_busy", 64'(mif.MUL_Busy), 64'd0);
      chk("reset_done", 64'(mif.MUL_Done), 64'd0);
      chk("reset_hilo", {mif.MUL_HI, mif.MUL_LO}, 64'd0);
      chk("reset_out", 64'(mif.MUL_Out), 64'd0);
      tick(); tick();
      mif.EXE_Valid = 1'b0;
      resetn = 1'b1;
      tick();
      #1;

      // Directed arithmetic
      run_op("mult_neg1x2", OP_MULT, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("multu_ffx2", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE);
      run_op("mul_shift", OP_MUL, 32'h0000_1234, 32'h0001_0000, 64'h0000_0000_1234_0000);
      run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op("multu_maxmax", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op("mult_negpos", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);

      // Randomised ops against the reference model
      for (int i = 0; i < 6; i++) begin
         ra = $urandom; rb = $urandom;
         rop = (i % 3 == 0) ? OP_MUL : ((i % 3 == 1) ? OP_MULT : OP_MULTU);
         mif.HI_In = $urandom; mif.LO_In = $urandom;
         run_op("rand", rop, ra, rb, model(rop, ra, rb, mif.HI_In, mif.LO_In));
      end
      mif.HI_In = 32'h0; mif.LO_In = 32'h0;

      // Stall in DONE with the op still valid: hold results, no restart
      mif.EXE_ALUOp = OP_MULT; mif.EXE_ResultA = 32'h0000_0010; mif.EXE_ResultB = 32'hFFFF_FFFF;
      mif.EXE_Valid = 1'b1; mif.EXE_Stall = 1'b1;
      sb.push_back(64'hFFFF_FFFF_FFFF_FFF0);
      tick(); tick(); tick();
      #1;
      chk("stall_done_first", 64'(mif.MUL_Done), 64'd1);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
      for (int i = 0; i < 4; i++) begin
         chk("stall_done_hold", 64'(mif.MUL_Done), 64'd1);
         chk("stall_busy", 64'(mif.MUL_Busy), 64'd0);
         chk("stall_hilo", {mif.MUL_HI, mif.MUL_LO}, e);
         tick();
         #1;
      end
      mif.EXE_Stall = 1'b0; mif.EXE_Valid = 1'b0;
      #1;
      chk("stall_release_done", 64'(mif.MUL_Done), 64'd1);
      tick();
      #1;
      chk("stall_idle_done", 64'(mif.MUL_Done), 64'd0);
      chk("stall_idle_busy", 64'(mif.MUL_Busy), 64'd0);
      last_res = e;

      // Flush in PP: no Done pulse, results untouched
      mif.EXE_ALUOp = OP_MULTU; mif.EXE_ResultA = 32'h1234_5678; mif.EXE_ResultB = 32'h9;
      mif.EXE_Valid = 1'b1;
      tick();
      mif.EXE_Valid = 1'b0; mif.EXE_Flush = 1'b1;
      #1;
      chk("flush_pp_busy", 64'(mif.MUL_Busy), 64'd0);
      chk("flush_pp_done", 64'(mif.MUL_Done), 64'd0);
      tick();
      mif.EXE_Flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("flush_no_done", 64'(mif.MUL_Done), 64'd0);
         chk("flush_no_busy", 64'(mif.MUL_Busy), 64'd0);
         chk("flush_hold", {mif.MUL_HI, mif.MUL_LO}, last_res);
         tick();
      end
      #1;

      // Reset during SUM clears everything immediately
      mif.EXE_ALUOp = OP_MULT; mif.EXE_ResultA = 32'h7; mif.EXE_ResultB = 32'h9;
      mif.EXE_Valid = 1'b1;
      tick();
      mif.EXE_Valid = 1'b0;
      tick();
      mif.EXE_Valid = 1'b1;
      resetn = 1'b0;
      #1;
      chk("rst_sum_busy", 64'(mif.MUL_Busy), 64'd0);
      chk("rst_sum_done", 64'(mif.MUL_Done), 64'd0);
      chk("rst_sum_hilo", {mif.MUL_HI, mif.MUL_LO}, 64'd0);
      chk("rst_sum_out", 64'(mif.MUL_Out), 64'd0);
      mif.EXE_Valid = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      #1;
      run_op("mult_after_rst", OP_MULT, 32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA);

      // Unrecognised opcode never starts
      mif.EXE_ALUOp = 5'h00; mif.EXE_Valid = 1'b1;
      #1;
      chk("badop_busy", 64'(mif.MUL_Busy), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         chk("badop_no_done", 64'(mif.MUL_Done), 64'd0);
      end
      mif.EXE_Valid = 1'b0;
      tick();
      #1;

      // Multiply-accumulate ops
      mif.HI_In = 32'h0; mif.LO_In = 32'hFFFF_FFFF;
`ifdef MUL_MADD_EN
      run_op("madd_carry", OP_MADD, 32'h1, 32'h1, 64'h0000_0001_0000_0000);
      run_op("msubu", OP_MSUBU, 32'h2, 32'h3, 64'h0000_0000_FFFF_FFF9);
      mif.HI_In = $urandom; mif.LO_In = $urandom;
      ra = $urandom; rb = $urandom;
      run_op("maddu_rand", OP_MADDU, ra, rb, model(OP_MADDU, ra, rb, mif.HI_In, mif.LO_In));
      run_op("msub_rand", OP_MSUB, rb, ra, model(OP_MSUB, rb, ra, mif.HI_In, mif.LO_In));
`else
      mif.EXE_ALUOp = OP_MADD; mif.EXE_ResultA = 32'h1; mif.EXE_ResultB = 32'h1;
      mif.EXE_Valid = 1'b1;
      #1;
      chk("madd_off_busy", 64'(mif.MUL_Busy), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         chk("madd_off_no_done", 64'(mif.MUL_Done), 64'd0);
         chk("madd_off_no_busy", 64'(mif.MUL_Busy), 64'd0);
      end
      mif.EXE_Valid = 1'b0;
`endif

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
